kth_ss_apb_arbiter: RTL

- Shares one subsystem APB slave port between two APB requesters: m0 (SoC interconnect) and m1 (debug/test master).
- Sequences each granted transfer onto the slave port.
- Bounds every slave access with a timeout watchdog, so a slave that never asserts PREADY (e.g. a tied-off subsystem) cannot hang the bus.
- Sits directly in front of the subsystem APB slave, inside the subsystem wrapper.

---
 rtl/kth_ss_apb_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/kth_ss_apb_arbiter.sv
// Two-requester APB arbiter in front of a single subsystem APB slave.
// Each granted transfer is sequenced onto the slave port, and a watchdog
// aborts any ACCESS phase the slave does not complete in time.
module kth_ss_apb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'h0BAD_0BAD
) (
  input  logic        clk_in,
  input  logic        reset_int,
  input  logic [31:0] m0_PADDR,
  input  logic        m0_PSEL,
  input  logic        m0_PENABLE,
  input  logic        m0_PWRITE,
  input  logic [31:0] m0_PWDATA,
  output logic [31:0] m0_PRDATA,
  output logic        m0_PREADY,
  output logic        m0_PSLVERR,
  input  logic [31:0] m1_PADDR,
  input  logic        m1_PSEL,
  input  logic        m1_PENABLE,
  input  logic        m1_PWRITE,
  input  logic [31:0] m1_PWDATA,
  output logic [31:0] m1_PRDATA,
  output logic        m1_PREADY,
  output logic        m1_PSLVERR,
  output logic [31:0] s_PADDR,
  output logic        s_PSEL,
  output logic        s_PENABLE,
  output logic        s_PWRITE,
  output logic [31:0] s_PWDATA,
  input  logic [31:0] s_PRDATA,
  input  logic        s_PREADY,
  input  logic        s_PSLVERR,
  input  logic [7:0]  ss_ctrl,
  input  logic        irq_en,
  input  logic        irq_clr,
  output logic        irq,
  output logic        timeout_sts
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_grant;
  logic [CNT_W-1:0] r_cnt;

  logic [AW-1:0]    r_s_paddr;
  logic             r_s_psel;
  logic             r_s_penable;
  logic             r_s_pwrite;
  logic [DW-1:0]    r_s_pwdata;

  logic [DW-1:0]    r_m0_prdata;
  logic             r_m0_pready;
  logic             r_m0_pslverr;
  logic [DW-1:0]    r_m1_prdata;
  logic             r_m1_pready;
  logic             r_m1_pslverr;

  logic             r_timeout_sts;
  logic             r_irq;

  logic             w_req0;
  logic             w_req1;
  logic             w_pick1;
  logic             w_timeout;
  logic             w_done;
  logic             w_to_set;
  logic [DW-1:0]    w_rsp_data;
  logic             w_rsp_err;
  logic             w_unused_inputs;

  // Request qualification and winner selection (m1 wins only if m0 is idle,
  // or on a round-robin tie when m0 was granted last).
  assign w_req0  = m0_PSEL & ss_ctrl[0];
  assign w_req1  = m1_PSEL & ss_ctrl[0];
  assign w_pick1 = w_req1 & (~w_req0 | (~ss_ctrl[1] & ~r_last_grant));

  // Watchdog and response selection; a ready slave beats a same-cycle timeout.
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_done     = (r_state == ST_ACCESS) & (s_PREADY | w_timeout);
  assign w_to_set   = (r_state == ST_ACCESS) & ~s_PREADY & w_timeout;
  assign w_rsp_data = s_PREADY ? s_PRDATA : ERR_RDATA;
  assign w_rsp_err  = s_PREADY ? s_PSLVERR : 1'b1;

  assign w_unused_inputs = ^{m0_PENABLE, m1_PENABLE, ss_ctrl[7:2]};

  // Transfer sequencer with registered slave and requester outputs.
  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= '0;
      r_s_paddr    <= '0;
      r_s_psel     <= 1'b0;
      r_s_penable  <= 1'b0;
      r_s_pwrite   <= 1'b0;
      r_s_pwdata   <= '0;
      r_m0_prdata  <= '0;
      r_m0_pready  <= 1'b0;
      r_m0_pslverr <= 1'b0;
      r_m1_prdata  <= '0;
      r_m1_pready  <= 1'b0;
      r_m1_pslverr <= 1'b0;
    end else begin
      r_m0_prdata  <= '0;
      r_m0_pready  <= 1'b0;
      r_m0_pslverr <= 1'b0;
      r_m1_prdata  <= '0;
      r_m1_pready  <= 1'b0;
      r_m1_pslverr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req0 | w_req1) begin
            r_grant      <= w_pick1;
            r_last_grant <= w_pick1;
            r_s_paddr    <= w_pick1 ? m1_PADDR  : m0_PADDR;
            r_s_pwrite   <= w_pick1 ? m1_PWRITE : m0_PWRITE;
            r_s_pwdata   <= w_pick1 ? m1_PWDATA : m0_PWDATA;
            r_s_psel     <= 1'b1;
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_s_penable <= 1'b1;
          r_state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done) begin
            if (r_grant) begin
              r_m1_pready  <= 1'b1;
              r_m1_prdata  <= w_rsp_data;
              r_m1_pslverr <= w_rsp_err;
            end else begin
              r_m0_pready  <= 1'b1;
              r_m0_prdata  <= w_rsp_data;
              r_m0_pslverr <= w_rsp_err;
            end
            r_s_paddr   <= '0;
            r_s_psel    <= 1'b0;
            r_s_penable <= 1'b0;
            r_s_pwrite  <= 1'b0;
            r_s_pwdata  <= '0;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky timeout flag (set beats clear) and one-cycle-delayed interrupt.
  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      r_timeout_sts <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      if (w_to_set) begin
        r_timeout_sts <= 1'b1;
      end else if (irq_clr) begin
        r_timeout_sts <= 1'b0;
      end
      r_irq <= r_timeout_sts & irq_en;
    end
  end

  assign s_PADDR     = r_s_paddr;
  assign s_PSEL      = r_s_psel;
  assign s_PENABLE   = r_s_penable;
  assign s_PWRITE    = r_s_pwrite;
  assign s_PWDATA    = r_s_pwdata;
  assign m0_PRDATA   = r_m0_prdata;
  assign m0_PREADY   = r_m0_pready;
  assign m0_PSLVERR  = r_m0_pslverr;
  assign m1_PRDATA   = r_m1_prdata;
  assign m1_PREADY   = r_m1_pready;
  assign m1_PSLVERR  = r_m1_pslverr;
  assign timeout_sts = r_timeout_sts;
  assign irq         = r_irq;

endmodule
